// File: rtl/int_generator.sv
// Purpose: issues MAX_INT level interrupts, each raised PERIOD cycles after arming and held until a store to ACK_ADDR acknowledges it.
// Latency: interrupt rises PERIOD edges after entering COUNT; the next period starts HOLDOFF edges after an acknowledge.
// Backpressure: none; the bridge write port is sampled every cycle, and an interrupt is held until it is acknowledged.
module int_generator #(
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter int          PERIOD   = 16,
    parameter int          HOLDOFF  = 4,
    parameter int          MAX_INT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [7:0]  int_count,
    output logic        busy,
    output logic        done,
    output logic        spurious_ack
);

    localparam int CNT_MAX = (PERIOD > HOLDOFF) ? PERIOD : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PERIOD_LOAD = CW'(PERIOD - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [7:0]    MAX_CNT     = 8'(MAX_INT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_ASSERT  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          irq_n;
    logic [7:0]    count_n;
    logic          done_n;
    logic          spur_n;
    logic          ack;

    // Byte-lane address bits never matter: any store into the ack word counts.
    logic unused_addr_bits;
    assign unused_addr_bits = ^m_int_addr[1:0];

    assign ack  = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (m_int_byteen != 4'd0);
    assign busy = (state != S_IDLE);

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        irq_n   = interrupt;
        count_n = int_count;
        done_n  = done;
        // A store hitting the ack word outside ASSERT is flagged, including
        // the trailing cycles of a multi-cycle store that land in HOLDOFF.
        spur_n  = spurious_ack | (ack && (state != S_ASSERT));

        case (state)
            S_IDLE: begin
                if (enable && !done) begin
                    state_n = S_COUNT;
                    cnt_n   = PERIOD_LOAD;
                end
            end
            S_COUNT: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else begin
                    state_n = S_ASSERT;
                    irq_n   = 1'b1;
                end
            end
            S_ASSERT: begin
                // The request is held even if enable drops; only an ack clears it.
                irq_n = 1'b1;
                if (ack) begin
                    irq_n   = 1'b0;
                    count_n = int_count + 8'd1;
                    if (count_n == MAX_CNT) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_HOLDOFF;
                        cnt_n   = HOLD_LOAD;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else if (enable) begin
                    state_n = S_COUNT;
                    cnt_n   = PERIOD_LOAD;
                end else begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                irq_n   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts at once and wins over any ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            interrupt    <= 1'b0;
            int_count    <= 8'd0;
            done         <= 1'b0;
            spurious_ack <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            interrupt    <= irq_n;
            int_count    <= count_n;
            done         <= done_n;
            spurious_ack <= spur_n;
        end
    end

endmodule

// File: tb/tb_int_generator.sv
// Purpose: scoreboard bench for int_generator; expected interrupt rises are queued when stimulus is driven.
// Latency: each queued entry carries the exact edge number at which interrupt must be first seen high.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_int_generator;

    localparam int PERIOD  = 16;
    localparam int HOLDOFF = 4;
    localparam int MAX_INT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;
    logic [7:0]  int_count;
    logic        busy;
    logic        done;
    logic        spurious_ack;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;

    typedef struct {
        int rise_edge;
        int cnt;
    } exp_t;
    exp_t sb_q[$];

    int_generator #(
        .ACK_ADDR(32'h0000_7F20),
        .PERIOD  (PERIOD),
        .HOLDOFF (HOLDOFF),
        .MAX_INT (MAX_INT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .m_int_addr  (m_int_addr),
        .m_int_byteen(m_int_byteen),
        .interrupt   (interrupt),
        .int_count   (int_count),
        .busy        (busy),
        .done        (done),
        .spurious_ack(spurious_ack)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge it equals the number of rising edges seen so far.
    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_no);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input int rise_edge, input int cnt);
        exp_t x;
        x.rise_edge = rise_edge;
        x.cnt       = cnt;
        sb_q.push_back(x);
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n = 0;
        while (!interrupt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!interrupt) check(tag, 32'(interrupt), 32'd1);
    endtask

    // Drives a bridge store for 'len' cycles, then idles the port.
    task automatic store(input logic [31:0] addr, input logic [3:0] be, input int len);
        m_int_addr   = addr;
        m_int_byteen = be;
        tick(len);
        m_int_addr   = 32'd0;
        m_int_byteen = 4'd0;
    endtask

    // Monitor: every rising edge of interrupt must match the head of the scoreboard.
    initial begin
        logic prev = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (interrupt && !prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_irq", 32'd1, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    check("irq_edge", 32'(edge_no), 32'(x.rise_edge));
                    check("irq_count", 32'(int_count), 32'(x.cnt));
                end
            end
            prev = interrupt;
        end
    end

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        m_int_addr   = 32'd0;
        m_int_byteen = 4'd0;
        tick(3);
        check("rst_irq",   32'(interrupt),    32'd0);
        check("rst_count", 32'(int_count),    32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_done",  32'(done),         32'd0);
        check("rst_spur",  32'(spurious_ack), 32'd0);
        reset = 1'b1;
        tick(1);

        // First interrupt: PERIOD edges after the edge that enters COUNT.
        enable = 1'b1;
        sb_push(edge_no + 1 + PERIOD, 0);
        tick(1);
        check("busy_on_arm", 32'(busy), 32'd1);
        wait_irq("irq1_timeout", 40);

        // Near-miss stores must not acknowledge.
        store(32'h0000_7F24, 4'hF, 1);
        check("wrong_addr_irq",   32'(interrupt), 32'd1);
        check("wrong_addr_count", 32'(int_count), 32'd0);
        store(32'h0000_7F20, 4'h0, 1);
        check("zero_be_irq",  32'(interrupt),    32'd1);
        check("zero_be_spur", 32'(spurious_ack), 32'd0);

        // Ack via byte address 0x7F23: low bits ignored; next rise HOLDOFF+PERIOD later.
        sb_push(edge_no + 1 + HOLDOFF + PERIOD, 1);
        store(32'h0000_7F23, 4'b0001, 1);
        check("ack1_irq",   32'(interrupt),    32'd0);
        check("ack1_count", 32'(int_count),    32'd1);
        check("ack1_busy",  32'(busy),         32'd1);
        check("ack1_spur",  32'(spurious_ack), 32'd0);
        wait_irq("irq2_timeout", 40);
        sb_push(edge_no + 1 + HOLDOFF + PERIOD, 2);
        store(32'h0000_7F20, 4'hF, 1);
        wait_irq("irq3_timeout", 40);

        // Final ack completes the run; enable stays high but nothing more is issued.
        store(32'h0000_7F20, 4'hF, 1);
        check("fin_count", 32'(int_count), 32'd3);
        check("fin_done",  32'(done),      32'd1);
        check("fin_busy",  32'(busy),      32'd0);
        check("fin_irq",   32'(interrupt), 32'd0);
        tick(100);
        check("post_done_irq",   32'(interrupt), 32'd0);
        check("post_done_count", 32'(int_count), 32'd3);
        check("post_done_busy",  32'(busy),      32'd0);

        // Reset clears done; an ack while IDLE is spurious.
        enable = 1'b0;
        reset  = 1'b0;
        tick(1);
        reset = 1'b1;
        check("rst2_done",  32'(done),      32'd0);
        check("rst2_count", 32'(int_count), 32'd0);
        store(32'h0000_7F20, 4'hF, 1);
        check("idle_spur",  32'(spurious_ack), 32'd1);
        check("idle_busy",  32'(busy),         32'd0);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("rst3_spur", 32'(spurious_ack), 32'd0);

        // Drop enable while COUNT holds cnt=5: back to IDLE, no interrupt.
        enable = 1'b1;
        tick(PERIOD - 5);
        check("count_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        tick(1);
        check("drop_busy", 32'(busy), 32'd0);
        tick(30);
        check("drop_irq", 32'(interrupt), 32'd0);

        // Drop enable in ASSERT: request held until ack, then HOLDOFF, then IDLE.
        enable = 1'b1;
        sb_push(edge_no + 1 + PERIOD, 0);
        tick(1);
        wait_irq("irq4_timeout", 40);
        enable = 1'b0;
        tick(5);
        check("hold_irq", 32'(interrupt), 32'd1);
        store(32'h0000_7F20, 4'hF, 1);
        check("hold_ack_irq",   32'(interrupt), 32'd0);
        check("hold_ack_count", 32'(int_count), 32'd1);
        tick(HOLDOFF - 1);
        check("holdoff_busy", 32'(busy), 32'd1);
        tick(1);
        check("holdoff_exit_busy", 32'(busy), 32'd0);
        tick(30);
        check("holdoff_exit_irq", 32'(interrupt), 32'd0);

        // Reset with interrupt high and two acks done, coincident with an ack.
        reset = 1'b0;
        tick(1);
        reset  = 1'b1;
        enable = 1'b1;
        sb_push(edge_no + 1 + PERIOD, 0);
        tick(1);
        wait_irq("irq5_timeout", 40);
        sb_push(edge_no + 1 + HOLDOFF + PERIOD, 1);
        store(32'h0000_7F20, 4'hF, 1);
        wait_irq("irq6_timeout", 40);
        // Two-cycle store: the second cycle lands in HOLDOFF and is spurious.
        sb_push(edge_no + 1 + HOLDOFF + PERIOD, 2);
        store(32'h0000_7F20, 4'hF, 2);
        check("multi_store_spur",  32'(spurious_ack), 32'd1);
        check("multi_store_count", 32'(int_count),    32'd2);
        wait_irq("irq7_timeout", 40);
        check("pre_rst_count", 32'(int_count), 32'd2);
        reset        = 1'b0;
        m_int_addr   = 32'h0000_7F20;
        m_int_byteen = 4'hF;
        tick(1);
        check("mid_rst_irq",   32'(interrupt),    32'd0);
        check("mid_rst_count", 32'(int_count),    32'd0);
        check("mid_rst_done",  32'(done),         32'd0);
        check("mid_rst_busy",  32'(busy),         32'd0);
        check("mid_rst_spur",  32'(spurious_ack), 32'd0);
        reset        = 1'b1;
        enable       = 1'b0;
        m_int_addr   = 32'd0;
        m_int_byteen = 4'd0;
        tick(2);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
